ciclo_decode: RTL and testbench

Decode stage that consumes the IF/ID pair (instruction word, PC+4) produced by the fetch stage and feeds the ID/EX pipeline register. It decodes the instruction, reads the register file, sign-extends the immediate, computes the jump and branch targets, and detects load-use hazards. On a hazard it asserts a stall back toward fetch, which holds the PC and IF/ID, and inserts a bubble.

---
 rtl/ciclo_decode_pkg.sv | 61 ++++++
 rtl/ciclo_decode_reg_file.sv | 28 ++
 rtl/ciclo_decode.sv | 117 +++++++++++
 tb/tb_ciclo_decode.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ciclo_decode_pkg.sv
// Shared decode definitions: opcodes, ALU operation classes and the control bundle.
package ciclo_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_FUNCT; end
      OP_LW: begin
        c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1;
      end
      OP_SW:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BEQ:  begin c.branch = 1'b1; c.alu_op = ALU_SUB; end
      OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OP_ANDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_AND; end
      OP_ORI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OR; end
      OP_SLTI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_SLT; end
      OP_J:    c.jump = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Logical immediates take a zero-extended operand.
  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/ciclo_decode_reg_file.sv
// Register file: two combinational read ports with same-cycle write bypass, one write port.
module ciclo_decode_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [2**ADDR_W-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   regs     <= '0;
    else if (we && wa != '0)   regs[wa] <= wd;
  end

  // Register 0 is hardwired; the bypass never forwards a write to it.
  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/ciclo_decode.sv
// Decode stage: IF/ID -> ID/EX register, register-file read, immediates, targets, load-use stall.
module ciclo_decode
  import ciclo_decode_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst_in,
  input  logic [31:0]          pc4_in,
  input  logic                 wb_we,
  input  logic [RF_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 ex_mem_read,
  input  logic [RF_ADDR_W-1:0] ex_rt,
  input  logic                 flush,
  output logic                 stall,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  output logic [31:0]          imm_ext,
  output logic [RF_ADDR_W-1:0] rs,
  output logic [RF_ADDR_W-1:0] rt,
  output logic [RF_ADDR_W-1:0] rd,
  output logic [4:0]           shamt,
  output logic [5:0]           funct,
  output logic [31:0]          pc4_out,
  output logic [31:0]          br_target,
  output logic [31:0]          j_target,
  output logic                 reg_dst,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 branch,
  output logic                 jump,
  output logic [2:0]           alu_op,
  output logic                 illegal
);

  logic [5:0]           op;
  logic [RF_ADDR_W-1:0] f_rs, f_rt, f_rd;
  logic [15:0]          imm;
  logic [31:0]          imm_s, imm_x;
  logic [DATA_W-1:0]    rd1, rd2;
  logic                 hazard;
  ctrl_t                dec, ctrl_q;

  assign op   = inst_in[31:26];
  assign f_rs = inst_in[25:21];
  assign f_rt = inst_in[20:16];
  assign f_rd = inst_in[15:11];
  assign imm  = inst_in[15:0];

  assign dec   = decode_op(op);
  assign imm_s = {{16{imm[15]}}, imm};
  assign imm_x = is_zext(op) ? {16'b0, imm} : imm_s;

  assign hazard = ex_mem_read && (ex_rt != '0) && (ex_rt == f_rs || ex_rt == f_rt);
  assign stall  = hazard && !flush;

  ciclo_decode_reg_file #(.DATA_W(DATA_W), .ADDR_W(RF_ADDR_W)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (f_rs),
    .ra2 (f_rt),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (wb_we),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // Data fields always capture; only the control bundle is squashed into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data   <= '0;
      rt_data   <= '0;
      imm_ext   <= '0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      shamt     <= '0;
      funct     <= '0;
      pc4_out   <= '0;
      br_target <= '0;
      j_target  <= '0;
      ctrl_q    <= '0;
    end else begin
      rs_data   <= rd1;
      rt_data   <= rd2;
      imm_ext   <= imm_x;
      rs        <= f_rs;
      rt        <= f_rt;
      rd        <= f_rd;
      shamt     <= inst_in[10:6];
      funct     <= inst_in[5:0];
      pc4_out   <= pc4_in;
      br_target <= pc4_in + (imm_s << 2);
      j_target  <= {pc4_in[31:28], inst_in[25:0], 2'b00};
      ctrl_q    <= (stall || flush) ? '0 : dec;
    end
  end

  assign reg_dst    = ctrl_q.reg_dst;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_ciclo_decode.sv
// Bench for ciclo_decode: directed plan cases plus random traffic against a behavioural model.
module tb_ciclo_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_in = '0, pc4_in = '0, wb_data = '0;
  logic        wb_we = 1'b0, ex_mem_read = 1'b0, flush = 1'b0;
  logic [4:0]  wb_addr = '0, ex_rt = '0;
  logic        stall;
  logic [31:0] rs_data, rt_data, imm_ext, pc4_out, br_target, j_target;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;
  logic [31:0] mrf [32];

  always #5 clk = ~clk;

  ciclo_decode dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .pc4_in(pc4_in),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush), .stall(stall),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .pc4_out(pc4_out), .br_target(br_target), .j_target(j_target),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .alu_op(alu_op), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ctrl_word();
    return {illegal, alu_op, reg_dst, alu_src, mem_to_reg, reg_write,
            mem_read, mem_write, branch, jump};
  endfunction

  // Reference control table: {illegal, alu_op, rd,as,mtr,rw,mr,mw,br,j}
  function automatic logic [11:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'd0:  return 12'b0_010_1001_0000;
      6'd35: return 12'b0_000_0111_1000;
      6'd43: return 12'b0_000_0100_0100;
      6'd4:  return 12'b0_001_0000_0010;
      6'd8:  return 12'b0_000_0101_0000;
      6'd12: return 12'b0_011_0101_0000;
      6'd13: return 12'b0_100_0101_0000;
      6'd10: return 12'b0_101_0101_0000;
      6'd2:  return 12'b0_000_0000_0001;
      default: return 12'b1_000_0000_0000;
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".rs_data"}, rs_data, 0);
    chk({tag, ".rt_data"}, rt_data, 0);
    chk({tag, ".imm"}, imm_ext, 0);
    chk({tag, ".fields"}, {6'b0, rs, rt, rd, shamt, funct}, 0);
    chk({tag, ".pc4"}, pc4_out, 0);
    chk({tag, ".br"}, br_target, 0);
    chk({tag, ".j"}, j_target, 0);
    chk({tag, ".ctrl"}, {20'b0, ctrl_word()}, 0);
  endtask

  // One decode cycle: drive, check stall, clock, check registered outputs.
  task automatic cyc(input string tag, input logic [31:0] inst, input logic [31:0] pc4,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic emr, input logic [4:0] ert, input logic fl);
    int unsigned s_rs, s_rt, op, imm;
    logic [31:0] e_rs, e_rt, e_imm, e_br, e_j;
    logic [11:0] e_ctrl;
    logic        haz, e_stall;
    inst_in = inst; pc4_in = pc4; wb_we = we; wb_addr = wa; wb_data = wd;
    ex_mem_read = emr; ex_rt = ert; flush = fl;
    s_rs = (inst >> 21) % 32;
    s_rt = (inst >> 16) % 32;
    op   = inst >> 26;
    imm  = inst % 65536;
    haz  = emr && ert != 0 && (ert == s_rs || ert == s_rt);
    e_stall = haz && !fl;
    e_rs = (s_rs == 0) ? 0 : (we && wa == s_rs) ? wd : mrf[s_rs];
    e_rt = (s_rt == 0) ? 0 : (we && wa == s_rt) ? wd : mrf[s_rt];
    e_imm = (op == 12 || op == 13 || imm < 32768) ? imm : imm + 32'hFFFF0000;
    e_br  = pc4 + 4 * ((imm < 32768) ? imm : imm + 32'hFFFF0000);
    e_j   = (pc4 & 32'hF000_0000) + 4 * (inst % 32'h0400_0000);
    e_ctrl = (e_stall || fl) ? 12'b0 : ref_ctrl(op[5:0]);
    #1;
    chk({tag, ".stall"}, {31'b0, stall}, {31'b0, e_stall});
    @(posedge clk);
    if (we && wa != 0) mrf[wa] = wd;
    #1;
    chk({tag, ".rs_data"}, rs_data, e_rs);
    chk({tag, ".rt_data"}, rt_data, e_rt);
    chk({tag, ".imm"}, imm_ext, e_imm);
    chk({tag, ".fields"}, {6'b0, rs, rt, rd, shamt, funct}, inst % 32'h0400_0000);
    chk({tag, ".pc4"}, pc4_out, pc4);
    chk({tag, ".br"}, br_target, e_br);
    chk({tag, ".j"}, j_target, e_j);
    chk({tag, ".ctrl"}, {20'b0, ctrl_word()}, {20'b0, e_ctrl});
  endtask

  logic [5:0] ops [10] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd12, 6'd13, 6'd10, 6'd2, 6'd63};

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    #2 chk_zero("reset");
    #10 rst = 1'b0;

    // 1: write R5, then add $3,$5,$0
    cyc("wr5", 32'h0, 32'h4, 1, 5, 32'h0000_1234, 0, 0, 0);
    cyc("add", 32'h00A0_1820, 32'h8, 0, 0, 0, 0, 0, 0);
    chk("add.rs_val", rs_data, 32'h0000_1234);
    chk("add.alu_op", {29'b0, alu_op}, 3'b010);
    // 2: lw with negative immediate, beq target
    cyc("lw", 32'h8C22_FFFC, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("lw.imm", imm_ext, 32'hFFFF_FFFC);
    cyc("beq", 32'h1022_0003, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("beq.br", br_target, 32'h0000_004C);
    // 3: load-use hazard on rs, then ex_rt=0
    cyc("haz", 32'h0100_1820, 32'h44, 0, 0, 0, 1, 8, 0);
    cyc("haz0", 32'h0000_1820, 32'h44, 0, 0, 0, 1, 0, 0);
    // 4: flush beats stall
    cyc("flush", 32'h0100_1820, 32'h48, 0, 0, 0, 1, 8, 1);
    // 5: bypass on rt, write to r0 ignored
    cyc("byp", 32'h0009_1820, 32'h4C, 1, 9, 32'hDEAD_BEEF, 0, 0, 0);
    chk("byp.rt_val", rt_data, 32'hDEAD_BEEF);
    cyc("r0w", 32'h0000_1820, 32'h50, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    cyc("r0r", 32'h0000_1820, 32'h54, 0, 0, 0, 0, 0, 0);
    chk("r0.val", rs_data, 32'h0);
    // 6: illegal opcode, jump target, hazard and writeback together
    cyc("ill", 32'hFC00_0000, 32'h58, 0, 0, 0, 0, 0, 0);
    chk("ill.flag", {31'b0, illegal}, 32'h1);
    cyc("j", 32'h0800_0100, 32'h1000_0004, 0, 0, 0, 0, 0, 0);
    chk("j.tgt", j_target, 32'h1000_0400);
    cyc("wbhaz", 32'h0109_1820, 32'h5C, 1, 9, 32'h0BAD_F00D, 1, 9, 0);
    cyc("wbchk", 32'h0009_1820, 32'h60, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r, inst, wd;
      logic [4:0]  wa, ert;
      r    = $urandom;
      inst = {ops[$urandom_range(0, 9)], r[25:0]};
      if (inst[31:26] == 6'd63) inst[31:26] = 6'($urandom);
      wa   = 5'($urandom);
      wd   = $urandom;
      case ($urandom_range(0, 3))
        0: ert = inst[25:21];
        1: ert = inst[20:16];
        default: ert = 5'($urandom);
      endcase
      cyc("rnd", inst, $urandom, ($urandom_range(0, 1) == 1), wa, wd,
          ($urandom_range(0, 1) == 1), ert, ($urandom_range(0, 4) == 0));
    end

    // mid-stream reset clears outputs and registers asynchronously
    cyc("pre", 32'h8C22_FFFC, 32'h100, 1, 5, 32'h5555_AAAA, 0, 0, 0);
    #3 rst = 1'b1;
    #1 chk_zero("midrst");
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    cyc("post", 32'h00A2_1820, 32'h200, 0, 0, 0, 0, 0, 0);
    chk("post.r5", rs_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
